round_load_sequencer: RTL and testbench
=======================================

ROUND_LOAD_SEQUENCER -- requirements
Module: round_load_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of all stream words.
REQ-002 Parameter TERMINATOR, default 32'hFFFFFFFF: end-of-round marker word.
REQ-003 Parameter TIMEOUT_CYCLES, default 65535: idle-cycle limit while waiting for decoder results.
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port reset_n  input  1  asynchronous active-low reset.
REQ-006 Ports host_in_data/host_in_valid/host_in_ready  in/in/out  32/1/1  stream from host input FIFO.
REQ-007 Ports dec_in_data/dec_in_valid/dec_in_ready  out/out/in  32/1/1  syndrome stream to Helios_single_FPGA input.
REQ-008 Ports dec_out_data/dec_out_valid/dec_out_ready  in/in/out  32/1/1  result stream from decoder output.
REQ-009 Ports host_out_data/host_out_valid/host_out_ready  out/out/in  32/1/1  result stream to host output FIFO.
REQ-010 Port busy  output  1  high in any state other than S_IDLE.
REQ-011 Ports test_id/syndrome_count/test_count  output  32/16/16  current test ID, syndromes loaded this round, completed rounds.
REQ-012 Ports last_cycles/last_iterations  output  16/8  counters reported by the decoder for the last round.
REQ-013 Port timeout_err  output  1  sticky result-timeout flag.

Function
REQ-014 FSM states SHALL be S_IDLE, S_LOAD, S_READ; a transfer occurs only on a cycle with valid and ready both high.
REQ-015 S_IDLE: host_in_ready=1, dec_in_valid=0, dec_out_ready=0, host_out_valid=0.
REQ-016 S_IDLE transfer of word != TERMINATOR: capture into test_id, clear syndrome_count, go to S_LOAD; the word is not forwarded.
REQ-017 S_IDLE transfer of word == TERMINATOR: discard the word, stay in S_IDLE, leave all registers unchanged.
REQ-018 S_LOAD: combinational pass-through (dec_in_data=host_in_data, dec_in_valid=host_in_valid, host_in_ready=dec_in_ready); zero added latency.
REQ-019 S_LOAD transfer of non-terminator word: syndrome_count increments, saturating at 16'hFFFF.
REQ-020 S_LOAD transfer of TERMINATOR: the word is forwarded to the decoder, the count is not incremented, and the FSM enters S_READ on the next cycle.
REQ-021 S_READ: host_in_ready=0, dec_in_valid=0; pass-through host_out_data=dec_out_data, host_out_valid=dec_out_valid, dec_out_ready=host_out_ready.
REQ-022 The first S_READ transfer of a round SHALL load last_cycles=data[15:0] and last_iterations=data[23:16]; later words SHALL NOT update them.
REQ-023 S_READ transfer of TERMINATOR: the word is forwarded to the host, test_count increments (wrapping 16'hFFFF->0), and the FSM returns to S_IDLE.
REQ-024 A round with a TERMINATOR as the first result word SHALL load last_cycles/last_iterations from it (FFFF/FF) and also complete the round.
REQ-025 When dec_out_valid and host_out_ready are high together in the same cycle, the data word SHALL be passed through unregistered in that cycle.
REQ-026 In S_IDLE and S_LOAD, dec_out_valid SHALL be ignored and held back (dec_out_ready=0).

Reset
REQ-027 While reset_n is low: state=S_IDLE; test_id, syndrome_count, test_count, last_cycles, last_iterations, timeout_err=0; busy=0.
REQ-028 A reset mid-round SHALL abandon the round without any further handshake; the external FIFOs are not flushed by this block.
REQ-029 Reset deassertion SHALL be synchronised internally so that the first transfer can occur on the 2nd rising edge after release.

Configuration
REQ-030 Macro ROUND_LOAD_SEQ_TIMEOUT_EN defined: a 16-bit counter clears on S_READ entry and on every S_READ transfer, and increments on other S_READ cycles.
REQ-031 With the macro defined, when the counter reaches TIMEOUT_CYCLES: set timeout_err (cleared only by reset), go to S_IDLE, leave test_count unchanged.
REQ-032 Macro undefined: no timeout counter; S_READ waits indefinitely; timeout_err is tied to 0.

Verification
REQ-033 Host sends 0x00000007, 0x00010002, 0x00030004, 0xFFFFFFFF -> decoder receives the last 3 words in order; test_id=7, syndrome_count=2, state S_READ.
REQ-034 Decoder returns 0x0003002A, 0x00000000, 0xFFFFFFFF -> host receives all 3 words; last_cycles=42, last_iterations=3, test_count=1, state S_IDLE.
REQ-035 Host sends 0xFFFFFFFF while in S_IDLE -> word consumed, nothing reaches the decoder, all registers unchanged.
REQ-036 dec_in_ready held low for 5 cycles during S_LOAD -> host_in_ready is low for the same 5 cycles, no words lost or duplicated, syndrome_count exact.
REQ-037 reset_n pulsed low in S_READ after 1 result word -> all outputs return to 0 and state S_IDLE; the next round with ID 0x9 runs normally.
REQ-038 With ROUND_LOAD_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, no decoder output -> timeout_err=1 after 16 S_READ cycles, state S_IDLE, test_count unchanged.

Source files
------------

// File: rtl/round_load_sequencer.sv
// Round load sequencer: forwards one round of host syndromes to the decoder, then relays its results back.
// Optional result-timeout supervision is enabled by defining ROUND_LOAD_SEQ_TIMEOUT_EN.
module round_load_sequencer #(
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter logic [DATA_WIDTH-1:0] TERMINATOR     = {DATA_WIDTH{1'b1}},
    parameter int unsigned           TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic [DATA_WIDTH-1:0] host_in_data,
    input  logic                  host_in_valid,
    output logic                  host_in_ready,

    output logic [DATA_WIDTH-1:0] dec_in_data,
    output logic                  dec_in_valid,
    input  logic                  dec_in_ready,

    input  logic [DATA_WIDTH-1:0] dec_out_data,
    input  logic                  dec_out_valid,
    output logic                  dec_out_ready,

    output logic [DATA_WIDTH-1:0] host_out_data,
    output logic                  host_out_valid,
    input  logic                  host_out_ready,

    output logic                  busy,
    output logic [DATA_WIDTH-1:0] test_id,
    output logic [15:0]           syndrome_count,
    output logic [15:0]           test_count,
    output logic [15:0]           last_cycles,
    output logic [7:0]            last_iterations,
    output logic                  timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_READ = 2'd2
    } state_t;

`ifdef ROUND_LOAD_SEQ_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    // The counter value seen on the last idle S_READ cycle before the limit is reached.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t                state_q, state_d;
    logic                  run_q;
    logic [DATA_WIDTH-1:0] test_id_q, test_id_d;
    logic [15:0]           syn_cnt_q, syn_cnt_d;
    logic [15:0]           test_cnt_q, test_cnt_d;
    logic [15:0]           last_cyc_q, last_cyc_d;
    logic [7:0]            last_iter_q, last_iter_d;
    logic                  first_q, first_d;
    logic [15:0]           tmo_cnt_q, tmo_cnt_d;
    logic                  tmo_err_q, tmo_err_d;
    logic                  tmo_hit;

    // Reset release is re-timed so handshakes open only after the first clean edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // NOTE: every register is cleared by the asynchronous reset; there is no memory array here
    // that would need to be left uninitialised, so all state restarts from a known value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            test_id_q   <= '0;
            syn_cnt_q   <= '0;
            test_cnt_q  <= '0;
            last_cyc_q  <= '0;
            last_iter_q <= '0;
            first_q     <= 1'b0;
            tmo_cnt_q   <= '0;
            tmo_err_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples
            // the pre-edge values; the combinational block below uses blocking ones.
            state_q     <= state_d;
            test_id_q   <= test_id_d;
            syn_cnt_q   <= syn_cnt_d;
            test_cnt_q  <= test_cnt_d;
            last_cyc_q  <= last_cyc_d;
            last_iter_q <= last_iter_d;
            first_q     <= first_d;
            tmo_cnt_q   <= tmo_cnt_d;
            tmo_err_q   <= tmo_err_d;
        end
    end

    assign tmo_hit = TIMEOUT_EN && (tmo_cnt_q == TIMEOUT_LAST);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d        = state_q;
        test_id_d      = test_id_q;
        syn_cnt_d      = syn_cnt_q;
        test_cnt_d     = test_cnt_q;
        last_cyc_d     = last_cyc_q;
        last_iter_d    = last_iter_q;
        first_d        = first_q;
        tmo_cnt_d      = '0;
        tmo_err_d      = tmo_err_q;

        host_in_ready  = 1'b0;
        dec_in_valid   = 1'b0;
        dec_in_data    = host_in_data;
        dec_out_ready  = 1'b0;
        host_out_valid = 1'b0;
        host_out_data  = dec_out_data;

        unique case (state_q)
            S_IDLE: begin
                host_in_ready = run_q;
                if (host_in_valid && run_q && (host_in_data != TERMINATOR)) begin
                    test_id_d = host_in_data;
                    syn_cnt_d = '0;
                    state_d   = S_LOAD;
                end
            end

            S_LOAD: begin
                dec_in_valid  = host_in_valid;
                host_in_ready = dec_in_ready;
                if (host_in_valid && dec_in_ready) begin
                    if (host_in_data == TERMINATOR) begin
                        state_d = S_READ;
                        first_d = 1'b1;
                    end else if (syn_cnt_q != 16'hFFFF) begin
                        syn_cnt_d = syn_cnt_q + 16'd1;
                    end
                end
            end

            S_READ: begin
                host_out_valid = dec_out_valid;
                dec_out_ready  = host_out_ready;
                if (dec_out_valid && host_out_ready) begin
                    if (first_q) begin
                        last_cyc_d  = dec_out_data[15:0];
                        last_iter_d = dec_out_data[23:16];
                        first_d     = 1'b0;
                    end
                    if (dec_out_data == TERMINATOR) begin
                        test_cnt_d = test_cnt_q + 16'd1;
                        state_d    = S_IDLE;
                    end
                end else if (tmo_hit) begin
                    tmo_err_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (TIMEOUT_EN) begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy            = (state_q != S_IDLE);
    assign test_id         = test_id_q;
    assign syndrome_count  = syn_cnt_q;
    assign test_count      = test_cnt_q;
    assign last_cycles     = last_cyc_q;
    assign last_iterations = last_iter_q;
    assign timeout_err     = tmo_err_q;

endmodule

// File: tb/tb_round_load_sequencer.sv
// Directed bench for round_load_sequencer: load/read rounds, backpressure, idle terminator, mid-round reset.
module tb_round_load_sequencer;

    localparam logic [31:0] TERM = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] host_in_data = '0;
    logic        host_in_valid = 1'b0;
    logic        host_in_ready;
    logic [31:0] dec_in_data;
    logic        dec_in_valid;
    logic        dec_in_ready = 1'b1;
    logic [31:0] dec_out_data = '0;
    logic        dec_out_valid = 1'b0;
    logic        dec_out_ready;
    logic [31:0] host_out_data;
    logic        host_out_valid;
    logic        host_out_ready = 1'b1;
    logic        busy;
    logic [31:0] test_id;
    logic [15:0] syndrome_count;
    logic [15:0] test_count;
    logic [15:0] last_cycles;
    logic [7:0]  last_iterations;
    logic        timeout_err;

    int checks = 0;
    int failures = 0;

    logic [31:0] dec_q[$];
    logic [31:0] host_q[$];

    round_load_sequencer #(
        .DATA_WIDTH     (32),
        .TERMINATOR     (32'hFFFFFFFF),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .host_in_data    (host_in_data),
        .host_in_valid   (host_in_valid),
        .host_in_ready   (host_in_ready),
        .dec_in_data     (dec_in_data),
        .dec_in_valid    (dec_in_valid),
        .dec_in_ready    (dec_in_ready),
        .dec_out_data    (dec_out_data),
        .dec_out_valid   (dec_out_valid),
        .dec_out_ready   (dec_out_ready),
        .host_out_data   (host_out_data),
        .host_out_valid  (host_out_valid),
        .host_out_ready  (host_out_ready),
        .busy            (busy),
        .test_id         (test_id),
        .syndrome_count  (syndrome_count),
        .test_count      (test_count),
        .last_cycles     (last_cycles),
        .last_iterations (last_iterations),
        .timeout_err     (timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dec_in_valid && dec_in_ready) dec_q.push_back(dec_in_data);
        if (host_out_valid && host_out_ready) host_q.push_back(host_out_data);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        host_in_valid = 1'b0;
        dec_out_valid = 1'b0;
        dec_in_ready = 1'b1;
        host_out_ready = 1'b1;
        repeat (2) step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic send_host(input logic [31:0] w);
        bit done = 1'b0;
        host_in_data = w;
        host_in_valid = 1'b1;
        #1;
        for (int i = 0; i < 50 && !done; i++) begin
            if (host_in_ready) done = 1'b1;
            step();
        end
        host_in_valid = 1'b0;
        if (!done) begin
            checks++; failures++;
            $display("FAIL send_host_timeout word=%h never accepted", w);
        end
    endtask

    task automatic send_dec(input logic [31:0] w);
        bit done = 1'b0;
        dec_out_data = w;
        dec_out_valid = 1'b1;
        host_out_ready = 1'b1;
        #1;
        for (int i = 0; i < 50 && !done; i++) begin
            if (dec_out_ready) done = 1'b1;
            step();
        end
        dec_out_valid = 1'b0;
        if (!done) begin
            checks++; failures++;
            $display("FAIL send_dec_timeout word=%h never accepted", w);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (host_in_ready !== 1'b0) begin failures++; $display("FAIL rst_host_in_ready got=%b exp=0", host_in_ready); end
        checks++; if ({test_id, syndrome_count, test_count} !== 64'h0) begin failures++; $display("FAIL rst_regs got=%h exp=0", {test_id, syndrome_count, test_count}); end
        checks++; if ({last_cycles, last_iterations, timeout_err} !== 25'h0) begin failures++; $display("FAIL rst_last got=%h exp=0", {last_cycles, last_iterations, timeout_err}); end
        reset_n = 1'b1;
        host_in_data = 32'h5;
        host_in_valid = 1'b1;
        #1;
        checks++; if (host_in_ready !== 1'b0) begin failures++; $display("FAIL rst_release_ready0 got=%b exp=0", host_in_ready); end
        step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_edge1_busy got=%b exp=0", busy); end
        checks++; if (host_in_ready !== 1'b1) begin failures++; $display("FAIL rst_edge1_ready got=%b exp=1", host_in_ready); end
        step();
        host_in_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_edge2_busy got=%b exp=1", busy); end
        checks++; if (test_id !== 32'h5) begin failures++; $display("FAIL rst_edge2_test_id got=%h exp=5", test_id); end
        do_reset();
    endtask

    task automatic test_load();
        dec_q.delete();
        send_host(32'h00000007);
        host_in_data = 32'h00010002;
        host_in_valid = 1'b1;
        #1;
        checks++; if (dec_in_valid !== 1'b1 || dec_in_data !== 32'h00010002) begin failures++; $display("FAIL load_passthru got=%b/%h exp=1/00010002", dec_in_valid, dec_in_data); end
        send_host(32'h00010002);
        send_host(32'h00030004);
        send_host(TERM);
        checks++; if (dec_q.size() !== 3) begin failures++; $display("FAIL load_dec_count got=%0d exp=3", dec_q.size()); end
        else if (dec_q[0] !== 32'h00010002 || dec_q[1] !== 32'h00030004 || dec_q[2] !== TERM) begin
            failures++; $display("FAIL load_dec_words got=%h %h %h exp=00010002 00030004 ffffffff", dec_q[0], dec_q[1], dec_q[2]);
        end
        checks++; if (test_id !== 32'h7) begin failures++; $display("FAIL load_test_id got=%h exp=7", test_id); end
        checks++; if (syndrome_count !== 16'd2) begin failures++; $display("FAIL load_syn_count got=%0d exp=2", syndrome_count); end
        checks++; if (busy !== 1'b1 || host_in_ready !== 1'b0 || dec_out_ready !== 1'b1) begin
            failures++; $display("FAIL load_in_read got=busy%b hir%b dor%b exp=1 0 1", busy, host_in_ready, dec_out_ready);
        end
    endtask

    task automatic test_read();
        host_q.delete();
        dec_out_data = 32'h0003002A;
        dec_out_valid = 1'b1;
        host_out_ready = 1'b1;
        #1;
        checks++; if (host_out_valid !== 1'b1 || host_out_data !== 32'h0003002A) begin failures++; $display("FAIL read_passthru got=%b/%h exp=1/0003002a", host_out_valid, host_out_data); end
        send_dec(32'h0003002A);
        send_dec(32'h00000000);
        send_dec(TERM);
        checks++; if (host_q.size() !== 3) begin failures++; $display("FAIL read_host_count got=%0d exp=3", host_q.size()); end
        else if (host_q[0] !== 32'h0003002A || host_q[1] !== 32'h0 || host_q[2] !== TERM) begin
            failures++; $display("FAIL read_host_words got=%h %h %h exp=0003002a 00000000 ffffffff", host_q[0], host_q[1], host_q[2]);
        end
        checks++; if (last_cycles !== 16'd42) begin failures++; $display("FAIL read_last_cycles got=%0d exp=42", last_cycles); end
        checks++; if (last_iterations !== 8'd3) begin failures++; $display("FAIL read_last_iter got=%0d exp=3", last_iterations); end
        checks++; if (test_count !== 16'd1) begin failures++; $display("FAIL read_test_count got=%0d exp=1", test_count); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL read_idle got=%b exp=0", busy); end
    endtask

    task automatic test_idle_terminator();
        dec_q.delete();
        send_host(TERM);
        checks++; if (dec_q.size() !== 0) begin failures++; $display("FAIL idle_term_fwd got=%0d exp=0", dec_q.size()); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_term_busy got=%b exp=0", busy); end
        checks++; if (test_id !== 32'h7 || syndrome_count !== 16'd2 || test_count !== 16'd1) begin
            failures++; $display("FAIL idle_term_regs got=%h/%0d/%0d exp=7/2/1", test_id, syndrome_count, test_count);
        end
        dec_out_data = 32'h12345678;
        dec_out_valid = 1'b1;
        host_out_ready = 1'b1;
        #1;
        checks++; if (dec_out_ready !== 1'b0 || host_out_valid !== 1'b0) begin failures++; $display("FAIL idle_dec_out_held got=%b/%b exp=0/0", dec_out_ready, host_out_valid); end
        step();
        dec_out_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        int stalls_seen = 0;
        send_host(32'h00000011);
        dec_q.delete();
        host_q.delete();
        dec_in_ready = 1'b0;
        host_in_data = 32'h0000000A;
        host_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (host_in_ready === 1'b0) stalls_seen++;
            step();
        end
        checks++; if (stalls_seen !== 5) begin failures++; $display("FAIL bp_ready_low got=%0d exp=5", stalls_seen); end
        checks++; if (syndrome_count !== 16'd0) begin failures++; $display("FAIL bp_syn_stall got=%0d exp=0", syndrome_count); end
        dec_in_ready = 1'b1;
        send_host(32'h0000000A);
        send_host(32'h0000000B);
        send_host(32'h0000000C);
        send_host(TERM);
        checks++; if (dec_q.size() !== 4) begin failures++; $display("FAIL bp_dec_count got=%0d exp=4", dec_q.size()); end
        else if (dec_q[0] !== 32'hA || dec_q[1] !== 32'hB || dec_q[2] !== 32'hC || dec_q[3] !== TERM) begin
            failures++; $display("FAIL bp_dec_words got=%h %h %h %h exp=a b c ffffffff", dec_q[0], dec_q[1], dec_q[2], dec_q[3]);
        end
        checks++; if (syndrome_count !== 16'd3) begin failures++; $display("FAIL bp_syn_count got=%0d exp=3", syndrome_count); end
        send_dec(32'h00050010);
        send_dec(32'h00070020);
        send_dec(TERM);
        checks++; if (last_cycles !== 16'h0010 || last_iterations !== 8'h05) begin
            failures++; $display("FAIL bp_first_word_only got=%h/%h exp=0010/05", last_cycles, last_iterations);
        end
        checks++; if (test_count !== 16'd2 || busy !== 1'b0) begin failures++; $display("FAIL bp_round_done got=%0d/%b exp=2/0", test_count, busy); end
    endtask

    task automatic test_terminator_first();
        send_host(32'h00000022);
        send_host(TERM);
        checks++; if (syndrome_count !== 16'd0 || busy !== 1'b1) begin failures++; $display("FAIL tf_empty_load got=%0d/%b exp=0/1", syndrome_count, busy); end
        send_dec(TERM);
        checks++; if (last_cycles !== 16'hFFFF || last_iterations !== 8'hFF) begin
            failures++; $display("FAIL tf_last got=%h/%h exp=ffff/ff", last_cycles, last_iterations);
        end
        checks++; if (test_count !== 16'd3 || busy !== 1'b0) begin failures++; $display("FAIL tf_done got=%0d/%b exp=3/0", test_count, busy); end
    endtask

    task automatic test_mid_reset();
        send_host(32'h00000033);
        send_host(32'h00000001);
        send_host(TERM);
        send_dec(32'h00010001);
        checks++; if (busy !== 1'b1 || last_cycles !== 16'd1) begin failures++; $display("FAIL mr_pre got=%b/%0d exp=1/1", busy, last_cycles); end
        reset_n = 1'b0;
        #1;
        checks++; if ({busy, host_in_ready, dec_in_valid, dec_out_ready, host_out_valid, timeout_err} !== 6'b0) begin
            failures++; $display("FAIL mr_ctrl got=%b exp=000000", {busy, host_in_ready, dec_in_valid, dec_out_ready, host_out_valid, timeout_err});
        end
        checks++; if ({test_id, syndrome_count, test_count, last_cycles, last_iterations} !== 88'h0) begin
            failures++; $display("FAIL mr_regs got=%h exp=0", {test_id, syndrome_count, test_count, last_cycles, last_iterations});
        end
        step();
        reset_n = 1'b1;
        step();
        send_host(32'h00000009);
        send_host(32'h00000001);
        send_host(TERM);
        send_dec(32'h00020003);
        send_dec(TERM);
        checks++; if (test_id !== 32'h9 || syndrome_count !== 16'd1) begin failures++; $display("FAIL mr_next_load got=%h/%0d exp=9/1", test_id, syndrome_count); end
        checks++; if (test_count !== 16'd1 || last_cycles !== 16'd3 || last_iterations !== 8'd2 || busy !== 1'b0) begin
            failures++; $display("FAIL mr_next_read got=%0d/%0d/%0d/%b exp=1/3/2/0", test_count, last_cycles, last_iterations, busy);
        end
    endtask

`ifdef ROUND_LOAD_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        logic [15:0] tc_before;
        tc_before = test_count;
        send_host(32'h00000044);
        send_host(TERM);
        dec_out_valid = 1'b0;
        repeat (15) step();
        checks++; if (busy !== 1'b1 || timeout_err !== 1'b0) begin failures++; $display("FAIL to_early got=%b/%b exp=1/0", busy, timeout_err); end
        step();
        checks++; if (busy !== 1'b0 || timeout_err !== 1'b1) begin failures++; $display("FAIL to_fire got=%b/%b exp=0/1", busy, timeout_err); end
        checks++; if (test_count !== tc_before) begin failures++; $display("FAIL to_test_count got=%0d exp=%0d", test_count, tc_before); end
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_read();
        test_idle_terminator();
        test_backpressure();
        test_terminator_first();
        test_mid_reset();
`ifdef ROUND_LOAD_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
